// File: rtl/mult_seq_pkg.sv
// Shared definitions for the operand sequencer slice.
//   state_t      : sequencer FSM states
//   OPW          : operand width (one multiplier input)
//   PRODW        : product width returned by the multiplier
//   status_of()  : maps a state onto the LEDG status lamps
package mult_seq_pkg;

  localparam int unsigned OPW   = 2;
  localparam int unsigned PRODW = 4;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_CALC = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  // [0]=waiting for A, [1]=waiting for B, [2]=product valid
  function automatic logic [2:0] status_of(input state_t s);
    logic [2:0] st;
    st = '0;
    case (s)
      S_A:     st = 3'b001;
      S_B:     st = 3'b010;
      S_SHOW:  st = 3'b100;
      default: st = 3'b000;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mult_operand_sequencer_key_debounce.sv
// Pushbutton conditioning for the operand sequencer.
//   clk     : system clock
//   resetn  : asynchronous active-low reset
//   key_n   : raw active-low pushbutton, asynchronous to clk
//   press   : one-cycle pulse per debounced press
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  localparam int unsigned   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic          sync_d;   // previous synchronized sample, for change detection
  logic          level;    // accepted (debounced) key level, 1 = released
  logic          armed;    // a debounced release has been seen since reset
  logic [CW-1:0] cnt;
  logic          changed;
  logic          pending;
  logic [CW-1:0] eff_cnt;

  assign changed = (sync1 != sync_d);
  // After reset the key is presumed released but not yet proven so: a
  // full debounced high level must be seen before any press is honoured.
  assign pending = (sync1 != level) || (sync1 && !armed);
  // A change makes the current cycle the first stable one.
  assign eff_cnt = changed ? '0 : cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync0  <= 1'b1;
      sync1  <= 1'b1;
      sync_d <= 1'b1;
      level  <= 1'b1;
      armed  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync0  <= key_n;
      sync1  <= sync0;
      sync_d <= sync1;
      press  <= 1'b0;
      if (!pending) begin
        cnt <= '0;
      end else if (eff_cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync1;
        if (sync1) begin
          armed <= 1'b1;
        end else if (armed) begin
          press <= 1'b1;
        end
      end else begin
        cnt <= eff_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mult_operand_sequencer.sv
// Operand sequencer for an external 2-bit x 2-bit multiplier.
//   CLOCK_50 : system clock
//   resetn   : asynchronous active-low reset
//   SW       : operand value from slide switches
//   load_n   : raw active-low load pushbutton
//   op_out   : {B, A} operand bus to the multiplier
//   prod_in  : combinational product from the multiplier
//   LEDR     : registered product
//   LEDG     : status {valid, waiting B, waiting A}
module mult_operand_sequencer
  import mult_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic [OPW-1:0]     SW,
  input  logic               load_n,
  output logic [2*OPW-1:0]   op_out,
  input  logic [PRODW-1:0]   prod_in,
  output logic [PRODW-1:0]   LEDR,
  output logic [2:0]         LEDG
);

  state_t           state;
  logic [OPW-1:0]   op_a;
  logic [OPW-1:0]   op_b;
  logic [PRODW-1:0] prod_q;
  logic             press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .key_n  (load_n),
    .press  (press)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state  <= S_A;
      op_a   <= '0;
      op_b   <= '0;
      prod_q <= '0;
    end else begin
      case (state)
        S_A: begin
          if (press) begin
            op_a  <= SW;
            state <= S_B;
          end
        end
        S_B: begin
          if (press) begin
            op_b  <= SW;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          prod_q <= prod_in;
          state  <= S_SHOW;
        end
        S_SHOW: begin
          // New A starts the next round; the old product stays displayed.
          if (press) begin
            op_a  <= SW;
            state <= S_B;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

  assign op_out = {op_b, op_a};
  assign LEDR   = prod_q;
  assign LEDG   = status_of(state);

endmodule
